match_result_arbiter: RTL

- Collects match pulses from up to 8 parallel character-matcher lanes fed by the SPI byte stream.
- Arbitrates simultaneous hits round-robin and buffers up to DEPTH result entries.
- Presents the entries as the 64-bit result_ids word read back over SPI (result area 11xxx).
- Tracks byte position within the current word from the stream (tuser = separator) and tags each hit with it.

---
 rtl/match_result_arbiter.sv | 95 +++++++++
 1 files changed

// File: rtl/match_result_arbiter.sv
// match_result_arbiter: round-robin collection of matcher-lane hits into an 8-entry result buffer,
// each entry tagged with the byte position inside the current word.
module match_result_arbiter #(
    parameter int LANES   = 8,
    parameter int DEPTH   = 8,
    parameter int POS_MAX = 31
) (
    input  logic             sclk,
    input  logic             rst_n,
    input  logic             en,
    input  logic [7:0]       result_mask,
    input  logic             s_axis_tvalid,
    input  logic             s_axis_tuser,
    input  logic [LANES-1:0] hit,
    output logic [63:0]      result_ids,
    output logic [3:0]       result_count,
    output logic             overflow,
    output logic             busy
);
    logic [4:0]  pos_q, pos_d;
    logic [7:0]  pend_q, pend_d;
    logic [4:0]  pend_pos_q [8];
    logic [4:0]  pend_pos_d [8];
    logic [2:0]  rr_q, rr_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [63:0] ids_q, ids_d;
    logic        ovf_q, ovf_d;
    logic [7:0]  hit_x, cap;
    logic [3:0]  idx;
    logic [2:0]  g;
    logic        gnt_v;

    always_comb begin
        hit_x = '0;
        hit_x[LANES-1:0] = hit;
        cap = hit_x & result_mask;
        pos_d = !s_axis_tvalid ? pos_q : s_axis_tuser ? 5'd0 :
                (pos_q == 5'(POS_MAX)) ? pos_q : pos_q + 5'd1;
        // first pending lane at or after rr, wrapping mod LANES
        gnt_v = 1'b0;
        g = 3'd0;
        idx = '0;
        for (int k = 0; k < LANES; k++) begin
            idx = 4'(rr_q) + 4'(k);
            if (idx >= 4'(LANES)) idx = idx - 4'(LANES);
            if (!gnt_v && pend_q[idx[2:0]]) begin
                gnt_v = 1'b1;
                g = idx[2:0];
            end
        end
        rr_d = gnt_v ? ((g == 3'(LANES-1)) ? 3'd0 : g + 3'd1) : rr_q;
        ids_d = ids_q;
        cnt_d = cnt_q;
        ovf_d = ovf_q;
        if (gnt_v) begin
            if (cnt_q < 4'(DEPTH)) begin
                ids_d[{cnt_q[2:0], 3'b000} +: 8] = {g, pend_pos_q[g]};
                cnt_d = cnt_q + 4'd1;
            end else begin
                ovf_d = 1'b1;
            end
        end
        // a hit on a lane whose pending bit is being granted this cycle re-arms it
        for (int i = 0; i < 8; i++) begin
            pend_d[i] = cap[i] | (pend_q[i] & ~(gnt_v && g == 3'(i)));
            pend_pos_d[i] = (cap[i] && (!pend_q[i] || (gnt_v && g == 3'(i)))) ? pos_q : pend_pos_q[i];
            if (cap[i] && pend_q[i] && !(gnt_v && g == 3'(i))) ovf_d = 1'b1;
        end
    end

    always_ff @(posedge sclk) begin
        if (!rst_n || !en) begin
            pos_q  <= '0;
            pend_q <= '0;
            rr_q   <= '0;
            cnt_q  <= '0;
            ids_q  <= '1;
            ovf_q  <= 1'b0;
            for (int i = 0; i < 8; i++) pend_pos_q[i] <= '0;
        end else begin
            pos_q  <= pos_d;
            pend_q <= pend_d;
            rr_q   <= rr_d;
            cnt_q  <= cnt_d;
            ids_q  <= ids_d;
            ovf_q  <= ovf_d;
            for (int i = 0; i < 8; i++) pend_pos_q[i] <= pend_pos_d[i];
        end
    end

    assign result_ids   = ids_q;
    assign result_count = cnt_q;
    assign overflow     = ovf_q;
    assign busy         = |pend_q;
endmodule
